wf_decoder: RTL

- Receive-side counterpart to the serial waveform generator (intg).
- Samples the 1-bit serial waveform wf once per clock and searches for a known WIDTH-bit repeating pattern, transmitted MSB-first.
- Locks frame alignment once the pattern is found, then checks every subsequent frame against the pattern.
- Reports lock, per-frame good/bad pulses, a saturating error count and the last captured frame. Used on the bench and in loopback next to the generator.

---
 rtl/wf_pkg.sv | 14 +
 rtl/wf_shift_cmp.sv | 32 +++
 rtl/wf_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wf_pkg.sv
// Shared definitions for the serial waveform generator/decoder pair:
// decoder state encoding and the default frame pattern.
package wf_pkg;

  localparam int          WF_WIDTH   = 16;
  localparam logic [15:0] WF_PATTERN = 16'hA5C3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } wf_state_e;

endpackage : wf_pkg

// File: rtl/wf_shift_cmp.sv
// Serial-in shift register with a combinational look-ahead of the next
// window (nxt) and its equality compare against the expected pattern.
module wf_shift_cmp
  import wf_pkg::*;
#(
  parameter int               WIDTH   = WF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(WF_PATTERN)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             i_wf,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_match
);

  // Only WIDTH-1 history bits are stored: the oldest bit of a full window
  // falls out on the same edge the newest one arrives.
  logic [WIDTH-2:0] r_shreg;
  logic [WIDTH-1:0] w_nxt;

  assign w_nxt   = {r_shreg, i_wf};
  assign o_nxt   = w_nxt;
  assign o_match = (w_nxt == PATTERN);

  // NOTE: sequential state is updated with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) r_shreg <= '0;
    else       r_shreg <= w_nxt[WIDTH-2:0];
  end

endmodule : wf_shift_cmp

// File: rtl/wf_decoder.sv
// Frame-alignment decoder: finds PATTERN in the serial stream, verifies it
// for LOCK_FRAMES frames, then reports per-frame good/bad while locked.
module wf_decoder
  import wf_pkg::*;
#(
  parameter int               WIDTH       = WF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN     = WIDTH'(WF_PATTERN),
  parameter int               LOCK_FRAMES = 2,
  parameter int               LOSE_ERRS   = 3,
  parameter int               CNT_W       = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wf,
  output logic             locked,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] frame_data
);

  localparam int POS_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSE_ERRS + 1);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(WIDTH - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSE_ERRS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  wf_state_e         r_state, w_state_n;
  logic [POS_W-1:0]  r_pos, w_pos_n;
  logic [GOOD_W-1:0] r_good, w_good_n;
  logic [MISS_W-1:0] r_miss, w_miss_n;
  logic [CNT_W-1:0]  r_err_cnt, w_err_cnt_n;
  logic [WIDTH-1:0]  r_frame_data, w_frame_data_n;
  logic              r_locked, r_frame_ok, r_frame_err;
  logic              w_frame_ok_n, w_frame_err_n;

  logic [WIDTH-1:0]  w_nxt;
  logic              w_match;
  logic              w_boundary;

  wf_shift_cmp #(
    .WIDTH   (WIDTH),
    .PATTERN (PATTERN)
  ) u_shift_cmp (
    .clock   (clock),
    .clear   (clear),
    .i_wf    (wf),
    .o_nxt   (w_nxt),
    .o_match (w_match)
  );

  assign w_boundary = (r_pos == POS_LAST);

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_n      = r_state;
    w_pos_n        = r_pos;
    w_good_n       = r_good;
    w_miss_n       = r_miss;
    w_err_cnt_n    = r_err_cnt;
    w_frame_data_n = r_frame_data;
    w_frame_ok_n   = 1'b0;
    w_frame_err_n  = 1'b0;

    case (r_state)
      SEARCH: begin
        // Every bit offset is tried, which is what makes slip recovery work.
        if (w_match) begin
          w_pos_n        = '0;
          w_good_n       = GOOD_W'(1);
          w_frame_data_n = w_nxt;
          w_frame_ok_n   = 1'b1;
          if (LOCK_FRAMES == 1) begin
            w_state_n = LOCKED;
            w_miss_n  = '0;
          end else begin
            w_state_n = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (!w_boundary) begin
          w_pos_n = r_pos + 1'b1;
        end else begin
          w_pos_n = '0;
          if (w_match) begin
            w_frame_ok_n   = 1'b1;
            w_frame_data_n = w_nxt;
            w_good_n       = r_good + 1'b1;
            if (r_good == GOOD_LAST) begin
              w_state_n = LOCKED;
              w_miss_n  = '0;
            end
          end else begin
            w_state_n = SEARCH;
            w_good_n  = '0;
          end
        end
      end

      LOCKED: begin
        if (!w_boundary) begin
          w_pos_n = r_pos + 1'b1;
        end else begin
          w_pos_n        = '0;
          w_frame_data_n = w_nxt;
          if (w_match) begin
            w_frame_ok_n = 1'b1;
            w_miss_n     = '0;
          end else begin
            w_frame_err_n = 1'b1;
            if (r_err_cnt != CNT_MAX) w_err_cnt_n = r_err_cnt + 1'b1;
            if (r_miss == MISS_LAST) begin
              w_state_n = SEARCH;
              w_good_n  = '0;
              w_miss_n  = '0;
            end else begin
              w_miss_n = r_miss + 1'b1;
            end
          end
        end
      end

      default: w_state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= SEARCH;
      r_pos        <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_err_cnt    <= '0;
      r_frame_data <= '0;
      r_locked     <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pos        <= w_pos_n;
      r_good       <= w_good_n;
      r_miss       <= w_miss_n;
      r_err_cnt    <= w_err_cnt_n;
      r_frame_data <= w_frame_data_n;
      r_locked     <= (w_state_n == LOCKED);
      r_frame_ok   <= w_frame_ok_n;
      r_frame_err  <= w_frame_err_n;
    end
  end

  assign locked     = r_locked;
  assign frame_ok   = r_frame_ok;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;
  assign frame_data = r_frame_data;

endmodule : wf_decoder
